// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: ID-stage redirects, hazard stall, instruction-memory port and IF/ID outputs.
// The slave modport is the fetch unit; the master modport is the surrounding pipeline/memory.
interface pc_fetch_unit_if;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        j_valid;
    logic [31:0] j_target;
    logic        jr_valid;
    logic [31:0] jr_target;
    logic [31:0] imem_instr;
    logic [31:0] if_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        misalign_err;

    modport master (
        output stall, br_taken, br_target, j_valid, j_target, jr_valid, jr_target, imem_instr,
        input  if_pc, id_instr, id_pc, id_pc4, id_valid, misalign_err
    );

    modport slave (
        input  stall, br_taken, br_target, j_valid, j_target, jr_valid, jr_target, imem_instr,
        output if_pc, id_instr, id_pc, id_pc4, id_valid, misalign_err
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: PC register, next-PC selection with branch-delay-slot
// semantics, and the IF/ID pipeline register.
module pc_fetch_unit #(
    parameter logic [31:0] PC_INIT  = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset_n,
    pc_fetch_unit_if.slave bus
);

    typedef enum logic [0:0] {BOOT, RUN} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;
    logic        misalign_q, misalign_d;

    logic [31:0] seq_pc;
    logic [31:0] redirect_target;
    logic        redirect_sel;

    // Only the highest-priority redirect is considered: jr, then j/jal, then branch.
    always_comb begin
        seq_pc          = pc_q + 32'd4;
        redirect_sel    = 1'b0;
        redirect_target = seq_pc;
        if (bus.jr_valid) begin
            redirect_sel    = 1'b1;
            redirect_target = bus.jr_target;
        end else if (bus.j_valid) begin
            redirect_sel    = 1'b1;
            redirect_target = bus.j_target;
        end else if (bus.br_taken) begin
            redirect_sel    = 1'b1;
            redirect_target = bus.br_target;
        end
    end

    // The instruction in IF always advances into ID (delay slot); a redirect only steers the PC.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        misalign_d = misalign_q;
        if (!bus.stall) begin
            state_d    = RUN;
            id_instr_d = bus.imem_instr;
            id_pc_d    = pc_q;
            id_pc4_d   = seq_pc;
            id_valid_d = 1'b1;
            pc_d       = seq_pc;
            if ((state_q == RUN) && redirect_sel) begin
                pc_d = {redirect_target[31:2], 2'b00};
                if (redirect_target[1:0] != 2'b00) begin
                    misalign_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= BOOT;
            pc_q       <= PC_INIT;
            id_instr_q <= NOP_WORD;
            id_pc_q    <= 32'h0;
            id_pc4_q   <= 32'h0;
            id_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.if_pc        = pc_q;
    assign bus.id_instr     = id_instr_q;
    assign bus.id_pc        = id_pc_q;
    assign bus.id_pc4       = id_pc4_q;
    assign bus.id_valid     = id_valid_q;
    assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a small reference model pushes expected
// outputs into a scoreboard queue, popped and compared after each edge.
module tb_pc_fetch_unit;

    typedef struct {
        logic [31:0] if_pc;
        logic [31:0] id_instr;
        logic [31:0] id_pc;
        logic [31:0] id_pc4;
        logic        id_valid;
        logic        misalign;
    } exp_t;

    logic clk;
    logic reset_n;
    int   testCount = 0;
    int   failCount = 0;
    exp_t sbQ[$];

    logic        mRun;
    logic [31:0] mPc, mInstr, mIdPc, mIdPc4;
    logic        mValid, mErr;

    pc_fetch_unit_if bus ();

    pc_fetch_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [31:0] imemWord(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    assign bus.imem_instr = imemWord(bus.if_pc);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cmp32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        testCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic pushModel();
        exp_t e;
        e.if_pc    = mPc;
        e.id_instr = mInstr;
        e.id_pc    = mIdPc;
        e.id_pc4   = mIdPc4;
        e.id_valid = mValid;
        e.misalign = mErr;
        sbQ.push_back(e);
    endtask

    task automatic modelReset();
        mRun   = 1'b0;
        mPc    = 32'h0000_3000;
        mInstr = 32'h0000_0000;
        mIdPc  = 32'h0;
        mIdPc4 = 32'h0;
        mValid = 1'b0;
        mErr   = 1'b0;
        pushModel();
    endtask

    // Expected state after one rising edge given the inputs currently driven.
    task automatic modelEdge();
        logic [31:0] nxt;
        logic        redir;
        if (!bus.stall) begin
            nxt   = mPc + 32'd4;
            redir = mRun && (bus.jr_valid || bus.j_valid || bus.br_taken);
            if (mRun && bus.jr_valid)      nxt = bus.jr_target;
            else if (mRun && bus.j_valid)  nxt = bus.j_target;
            else if (mRun && bus.br_taken) nxt = bus.br_target;
            if (redir && (nxt[1:0] != 2'b00)) mErr = 1'b1;
            nxt[1:0] = 2'b00;
            mInstr = imemWord(mPc);
            mIdPc  = mPc;
            mIdPc4 = mPc + 32'd4;
            mValid = 1'b1;
            mRun   = 1'b1;
            mPc    = nxt;
        end
        pushModel();
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sbQ.size() == 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL %s: got empty scoreboard expected one entry", tag);
        end else begin
            e = sbQ.pop_front();
            cmp32({tag, ".if_pc"},    bus.if_pc,    e.if_pc);
            cmp32({tag, ".id_instr"}, bus.id_instr, e.id_instr);
            cmp32({tag, ".id_pc"},    bus.id_pc,    e.id_pc);
            cmp32({tag, ".id_pc4"},   bus.id_pc4,   e.id_pc4);
            cmp32({tag, ".id_valid"}, {31'h0, bus.id_valid}, {31'h0, e.id_valid});
            cmp32({tag, ".misalign"}, {31'h0, bus.misalign_err}, {31'h0, e.misalign});
        end
    endtask

    task automatic applyStimulus(input string tag, input logic st,
                                 input logic br, input logic [31:0] brT,
                                 input logic j,  input logic [31:0] jT,
                                 input logic jr, input logic [31:0] jrT);
        bus.stall     = st;
        bus.br_taken  = br;
        bus.br_target = brT;
        bus.j_valid   = j;
        bus.j_target  = jT;
        bus.jr_valid  = jr;
        bus.jr_target = jrT;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0;
        bus.j_valid = 1'b0; bus.j_target = '0; bus.jr_valid = 1'b0; bus.jr_target = '0;
        @(posedge clk);
        #1;
        modelReset();
        checkOutput("reset");
        cmp32("reset_if_pc", bus.if_pc, 32'h0000_3000);
        reset_n = 1'b1;

        applyStimulus("seq1", 0, 0, 0, 0, 0, 0, 0);
        cmp32("seq1_id_pc", bus.id_pc, 32'h0000_3000);
        cmp32("seq1_id_instr", bus.id_instr, 32'hC0DE_3000);
        applyStimulus("seq2", 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("seq3", 0, 0, 0, 0, 0, 0, 0);
        cmp32("seq3_if_pc", bus.if_pc, 32'h0000_300C);

        applyStimulus("branch", 0, 1, 32'h3040, 0, 0, 0, 0);
        cmp32("branch_delay_slot", bus.id_pc, 32'h0000_300C);
        cmp32("branch_if_pc", bus.if_pc, 32'h0000_3040);
        applyStimulus("post_branch", 0, 0, 0, 0, 0, 0, 0);

        applyStimulus("priority", 0, 1, 32'h3300, 1, 32'h3200, 1, 32'h3100);
        cmp32("priority_if_pc", bus.if_pc, 32'h0000_3100);

        applyStimulus("stall1", 1, 0, 0, 1, 32'h3080, 0, 0);
        applyStimulus("stall2", 1, 0, 0, 1, 32'h3080, 0, 0);
        cmp32("stall_if_pc", bus.if_pc, 32'h0000_3100);
        applyStimulus("unstall_j", 0, 0, 0, 1, 32'h3080, 0, 0);
        cmp32("unstall_if_pc", bus.if_pc, 32'h0000_3080);

        applyStimulus("misalign", 0, 0, 0, 0, 0, 1, 32'h3013);
        cmp32("misalign_if_pc", bus.if_pc, 32'h0000_3010);
        cmp32("misalign_flag", {31'h0, bus.misalign_err}, 32'h1);
        applyStimulus("sticky_j", 0, 0, 0, 1, 32'h3200, 0, 0);
        applyStimulus("sticky_br", 0, 1, 32'h3300, 0, 0, 0, 0);
        cmp32("sticky_flag", {31'h0, bus.misalign_err}, 32'h1);

        // Asynchronous reset in the middle of a cycle carrying a taken branch.
        bus.br_taken = 1'b1; bus.br_target = 32'h3040;
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset");
        @(posedge clk);
        #1;
        modelReset();
        checkOutput("reset_held");
        reset_n = 1'b1;

        applyStimulus("boot_stall", 1, 1, 32'h3040, 0, 0, 0, 0);
        cmp32("boot_stall_valid", {31'h0, bus.id_valid}, 32'h0);
        applyStimulus("restart", 0, 1, 32'h3040, 0, 0, 0, 0);
        cmp32("restart_if_pc", bus.if_pc, 32'h0000_3004);
        applyStimulus("to_top", 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        applyStimulus("wrap", 0, 0, 0, 0, 0, 0, 0);
        cmp32("wrap_if_pc", bus.if_pc, 32'h0000_0000);
        cmp32("wrap_id_pc4", bus.id_pc4, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch front end of the five-stage pipelined core. It owns the PC register and the IF/ID pipeline register, and selects the next PC from sequential flow or ID-stage redirects: branch target (PC+4 + sign-extended offset), j/jal target, or jr register target. It consumes the immediates and targets the ID stage builds and returns the ID-stage PC and PC+4 those computations need. It sits between instruction memory and the ID-stage decoder/extender, with branch-delay-slot semantics.

## Interface

- PC_INIT, 32'h0000_3000, PC value loaded on reset (first fetch address)
- NOP_WORD, 32'h0000_0000, instruction word injected into ID during the boot bubble

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard-unit stall; holds PC and IF/ID
- br_taken  in  1  ID-stage conditional branch resolved taken
- br_target  in  32  ID-stage branch target (id_pc4 + offset<<2)
- j_valid  in  1  ID-stage j/jal
- j_target  in  32  {id_pc[31:28], index, 2'b00}
- jr_valid  in  1  ID-stage jr/jalr
- jr_target  in  32  forwarded rs value
- imem_instr  in  32  instruction word at if_pc (combinational imem read)
- if_pc  out  32  current fetch address to instruction memory
- id_instr  out  32  IF/ID registered instruction
- id_pc  out  32  IF/ID registered PC
- id_pc4  out  32  IF/ID registered PC+4
- id_valid  out  1  ID holds a real fetched instruction (0 during boot bubble)
- misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0

## Operation

- States: BOOT, RUN. Reset enters BOOT; BOOT -> RUN on the first edge after reset release with stall=0; RUN is left only by reset.
- BOOT: if_pc = PC_INIT; id_instr = NOP_WORD, id_valid = 0; redirect inputs ignored.
- RUN, stall=0, each edge: IF/ID <= {imem_instr, if_pc, if_pc+4}, id_valid <= 1; PC <= next_pc.
- next_pc priority: jr_valid -> jr_target; else j_valid -> j_target; else br_taken -> br_target; else if_pc + 4. Only the highest-priority active source is used.
- Delay slot: the redirect raised by the instruction in ID does not squash the instruction in IF; that instruction enters ID normally, and the target is fetched the cycle after.
- stall=1: PC, IF/ID, state and id_valid hold; redirect inputs are ignored that cycle (ID re-presents them when the stall clears).
- Misaligned redirect: a selected target with [1:0] != 0 is loaded with [1:0] forced to 2'b00, and misalign_err sets. Cleared only by reset. Sequential PC+4 never sets it.
- Arithmetic: 32-bit modulo; PC 32'hFFFF_FFFC + 4 wraps to 0 with no flag.

## Timing

- Reset (asynchronous assert, any cycle, including mid-stall or mid-redirect): immediately if_pc = PC_INIT, id_instr = NOP_WORD, id_pc = 0, id_pc4 = 0, id_valid = 0, misalign_err = 0, state = BOOT.
- Release is sampled at the next rising edge; the first edge with reset_n=1 and stall=0 moves PC_INIT into ID.
- Fetch-to-ID latency: 1 cycle. Redirect-to-fetch latency: 1 cycle (ID-stage edge updates PC).
- if_pc is a pure register output; imem_instr is sampled at the same edge PC advances.
- Outputs change only on clk rising edge or reset assertion.

## Test plan

- Reset then 3 free-running cycles -> if_pc 0x3000, 0x3004, 0x3008, 0x300C; id_pc lags by one cycle; id_valid 0 then 1; first id_instr is NOP_WORD.
- br_taken=1, br_target=0x3040 while id_pc=0x3004 -> next id_pc 0x3008 (delay slot), then if_pc 0x3040.
- jr_valid=1 (0x3100), j_valid=1 (0x3200), br_taken=1 (0x3300) together -> if_pc 0x3100.
- stall=1 for 2 cycles with j_valid=1 -> if_pc and IF/ID frozen, redirect ignored; stall clears with j_valid still 1, target 0x3080 -> if_pc 0x3080 next cycle.
- jr_target 0x3013 -> if_pc 0x3010, misalign_err=1 and stays 1 through later redirects until reset_n pulses low.
- Assert reset_n=0 mid-cycle during a taken branch -> outputs reach reset values before the next edge; after release, fetch restarts at 0x3000.
